// File: rtl/axi_sram.sv
`timescale 1ns/1ps
// axi_sram: AXI4 responder (AW/W/B and AR/R) backed by byte-writable RAM.
// Write and read channels each have their own FSM and each move one beat
// per cycle. FIXED, INCR and WRAP bursts are supported, up to 16 beats.
//
// Ports:
//   clk, rstn                   clock, async active-low reset
//   axi_AW*, axi_W*, axi_B*     write address / data / response channels
//   axi_AR*, axi_R*             read address / data channels
//
// Write FSM
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, consuming exactly LEN+1 data beats
//   W_RESP | BVALID high, holding the response until BREADY
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read address
//   R_BURST | streaming LEN+1 beats through RAM and output registers
module axi_sram #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_AW,
  input  logic        axi_AWVALID,
  output logic        axi_AWREADY,
  input  logic [1:0]  axi_AWBURST,
  input  logic [3:0]  axi_AWLEN,
  input  logic [2:0]  axi_AWSIZE,
  input  logic [31:0] axi_W,
  input  logic [3:0]  axi_WSTRB,
  input  logic        axi_WLAST,
  input  logic        axi_WVALID,
  output logic        axi_WREADY,
  output logic        axi_BVALID,
  input  logic        axi_BREADY,
  output logic [1:0]  axi_BRESP,
  input  logic [31:0] axi_AR,
  input  logic [1:0]  axi_ARBURST,
  input  logic [3:0]  axi_ARLEN,
  input  logic [2:0]  axi_ARSIZE,
  input  logic        axi_ARVALID,
  output logic        axi_ARREADY,
  output logic [31:0] axi_R,
  output logic        axi_RLAST,
  output logic [1:0]  axi_RRESP,
  output logic        axi_RVALID,
  input  logic        axi_RREADY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST} r_state_t;

  logic [31:0] mem [DEPTH];

  // Size, byte offset and upper address bits play no part in addressing.
  logic unused_bits;
  assign unused_bits = ^{axi_AWSIZE, axi_ARSIZE, axi_AW[31:ADDR_W+2], axi_AW[1:0],
                         axi_AR[31:ADDR_W+2], axi_AR[1:0]};

  // Word-address sequencing. WRAP keeps the upper bits and wraps the low
  // bits selected by LEN (a mask when LEN is 1/3/7/15); any other LEN or
  // the reserved type falls back to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [3:0] len,
                                                   input logic [1:0] burst);
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;
    mask    = ADDR_W'(len);
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    if (burst == 2'b00)
      return a;
    else if (burst == 2'b10 && wrap_ok)
      return (a & ~mask) | ((a + ONE) & mask);
    else
      return a + ONE;
  endfunction

  // ---------------- write channel ----------------
  w_state_t          w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              aw_hs, w_hs, b_hs;

  assign aw_hs = axi_AWVALID & axi_AWREADY;
  assign w_hs  = axi_WVALID & axi_WREADY & (w_state == W_DATA);
  assign b_hs  = axi_BVALID & axi_BREADY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && (w_cnt == w_len)) w_state_nx = W_RESP;
      W_RESP:  if (b_hs) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // BVALID is raised one cycle into W_RESP so the error flag from the
  // final beat has settled before the response is presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      axi_AWREADY <= 1'b0;
      axi_WREADY  <= 1'b0;
      axi_BVALID  <= 1'b0;
      axi_BRESP   <= 2'b00;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
    end else begin
      axi_AWREADY <= (w_state_nx == W_IDLE);
      axi_WREADY  <= (w_state_nx == W_DATA);
      axi_BVALID  <= (w_state == W_RESP) && (w_state_nx == W_RESP);
      axi_BRESP   <= ((w_state == W_RESP) && (w_state_nx == W_RESP) && w_err) ? 2'b10 : 2'b00;
      if (aw_hs) begin
        w_addr  <= axi_AW[ADDR_W+1:2];
        w_len   <= axi_AWLEN;
        w_burst <= axi_AWBURST;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 4'd1;
        if (axi_WLAST != (w_cnt == w_len)) w_err <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len, r_icnt;
  logic [1:0]        r_burst;
  logic              r_idone;
  logic [31:0]       ram_q;
  logic              q_vld, q_last;
  logic              ar_hs, r_adv, ram_re, r_last_hs;

  // RAM output (ram_q/q_vld) and axi_R form a two-stage pipe that
  // advances as a whole whenever the output slot is free or being taken.
  assign ar_hs     = axi_ARVALID & axi_ARREADY;
  assign r_adv     = (r_state == R_BURST) && (!axi_RVALID || axi_RREADY);
  assign ram_re    = r_adv && !r_idone;
  assign r_last_hs = axi_RVALID & axi_RREADY & axi_RLAST;
  assign axi_RRESP = 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_BURST;
      R_BURST: if (r_last_hs) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      axi_ARREADY <= 1'b0;
      axi_RVALID  <= 1'b0;
      axi_RLAST   <= 1'b0;
      axi_R       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_burst     <= '0;
      r_icnt      <= '0;
      r_idone     <= 1'b0;
      q_vld       <= 1'b0;
      q_last      <= 1'b0;
    end else begin
      axi_ARREADY <= (r_state_nx == R_IDLE);
      if (ar_hs) begin
        r_addr  <= axi_AR[ADDR_W+1:2];
        r_len   <= axi_ARLEN;
        r_burst <= axi_ARBURST;
        r_icnt  <= '0;
        r_idone <= 1'b0;
        q_vld   <= 1'b0;
        q_last  <= 1'b0;
      end else if (r_adv) begin
        if (!r_idone) begin
          q_vld   <= 1'b1;
          q_last  <= (r_icnt == r_len);
          r_idone <= (r_icnt == r_len);
          r_icnt  <= r_icnt + 4'd1;
          r_addr  <= next_addr(r_addr, r_len, r_burst);
        end else begin
          q_vld  <= 1'b0;
          q_last <= 1'b0;
        end
        if (q_vld) axi_R <= ram_q;
        axi_RVALID <= q_vld;
        axi_RLAST  <= q_vld & q_last;
      end
    end
  end

  // Array is not reset. Reading and writing the same word in one cycle
  // returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_WSTRB[b]) mem[w_addr][8*b +: 8] <= axi_W[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= mem[r_addr];
  end

endmodule

// File: tb/tb_axi_sram.sv
`timescale 1ns/1ps
module tb_axi_sram;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] axi_AW;
  logic        axi_AWVALID, axi_AWREADY;
  logic [1:0]  axi_AWBURST;
  logic [3:0]  axi_AWLEN;
  logic [2:0]  axi_AWSIZE;
  logic [31:0] axi_W;
  logic [3:0]  axi_WSTRB;
  logic        axi_WLAST, axi_WVALID, axi_WREADY;
  logic        axi_BVALID, axi_BREADY;
  logic [1:0]  axi_BRESP;
  logic [31:0] axi_AR;
  logic [1:0]  axi_ARBURST;
  logic [3:0]  axi_ARLEN;
  logic [2:0]  axi_ARSIZE;
  logic        axi_ARVALID, axi_ARREADY;
  logic [31:0] axi_R;
  logic        axi_RLAST;
  logic [1:0]  axi_RRESP;
  logic        axi_RVALID, axi_RREADY;

  axi_sram #(.ADDR_W(10)) dut (
    .clk(clk), .rstn(rstn),
    .axi_AW(axi_AW), .axi_AWVALID(axi_AWVALID), .axi_AWREADY(axi_AWREADY),
    .axi_AWBURST(axi_AWBURST), .axi_AWLEN(axi_AWLEN), .axi_AWSIZE(axi_AWSIZE),
    .axi_W(axi_W), .axi_WSTRB(axi_WSTRB), .axi_WLAST(axi_WLAST),
    .axi_WVALID(axi_WVALID), .axi_WREADY(axi_WREADY),
    .axi_BVALID(axi_BVALID), .axi_BREADY(axi_BREADY), .axi_BRESP(axi_BRESP),
    .axi_AR(axi_AR), .axi_ARBURST(axi_ARBURST), .axi_ARLEN(axi_ARLEN),
    .axi_ARSIZE(axi_ARSIZE), .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY),
    .axi_R(axi_R), .axi_RLAST(axi_RLAST), .axi_RRESP(axi_RRESP),
    .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wdata [16];
  logic [3:0]  wstrb [16];
  logic [31:0] rdata [16];
  logic        rlast_q [16];
  int          beat_k [16];
  int          rcnt, first_k;
  logic [1:0]  resp;
  int          bk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the write channel idle.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int last_at,
                           output logic [1:0] bresp, output int bcyc);
    int t;
    axi_AW = addr; axi_AWLEN = len; axi_AWBURST = burst; axi_AWSIZE = 3'd2;
    axi_AWVALID = 1'b1;
    t = 0;
    while (!axi_AWREADY && t < 50) begin @(negedge clk); t++; end
    chk("aw_wait", 32'(t < 50), 1);
    @(negedge clk);
    axi_AWVALID = 1'b0;
    chk("aw_ready_drop", 32'(axi_AWREADY), 0);
    chk("w_ready_rise", 32'(axi_WREADY), 1);
    for (int i = 0; i <= int'(len); i++) begin
      axi_W = wdata[i]; axi_WSTRB = wstrb[i]; axi_WLAST = (i == last_at);
      axi_WVALID = 1'b1;
      t = 0;
      while (!axi_WREADY && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    axi_WVALID = 1'b0; axi_WLAST = 1'b0;
    bcyc = 0;
    while (!axi_BVALID && bcyc < 50) begin @(negedge clk); bcyc++; end
    bresp = axi_BRESP;
    axi_BREADY = 1'b1;
    @(negedge clk);
    axi_BREADY = 1'b0;
    chk("aw_ready_after_b", 32'(axi_AWREADY), 1);
  endtask

  // Called at a negedge with the read channel idle. Beat timing is
  // recorded as k = negedges after the AR handshake edge.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit rnd);
    int t, k;
    logic stalled, pl, done;
    logic [31:0] pr;
    rcnt = 0; first_k = -1; done = 1'b0;
    axi_AR = addr; axi_ARLEN = len; axi_ARBURST = burst; axi_ARSIZE = 3'd2;
    axi_ARVALID = 1'b1;
    t = 0;
    while (!axi_ARREADY && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    axi_ARVALID = 1'b0;
    chk("ar_ready_drop", 32'(axi_ARREADY), 0);
    stalled = 1'b0; pr = '0; pl = 1'b0; k = 0;
    while (k < 300 && !done) begin
      if (stalled) begin
        chk("r_hold_data", axi_R, pr);
        chk("r_hold_valid", 32'(axi_RVALID), 1);
        chk("r_hold_last", 32'(axi_RLAST), 32'(pl));
      end
      axi_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_RVALID) begin
        if (first_k < 0) first_k = k;
        if (axi_RREADY) begin
          if (rcnt < 16) begin
            rdata[rcnt] = axi_R; rlast_q[rcnt] = axi_RLAST; beat_k[rcnt] = k;
          end
          rcnt++;
        end
      end
      stalled = axi_RVALID && !axi_RREADY;
      pr = axi_R; pl = axi_RLAST;
      done = axi_RVALID && axi_RREADY && axi_RLAST;
      @(negedge clk);
      k++;
    end
    axi_RREADY = 1'b0;
    chk("r_done", 32'(done), 1);
    chk("ar_ready_return", 32'(axi_ARREADY), 1);
  endtask

  initial begin
    int idx [4];
    logic [31:0] e;
    rstn = 1'b0;
    axi_AW = '0; axi_AWVALID = 0; axi_AWBURST = 2'b01; axi_AWLEN = '0; axi_AWSIZE = 3'd2;
    axi_W = '0; axi_WSTRB = '0; axi_WLAST = 0; axi_WVALID = 0; axi_BREADY = 0;
    axi_AR = '0; axi_ARBURST = 2'b01; axi_ARLEN = '0; axi_ARSIZE = 3'd2;
    axi_ARVALID = 0; axi_RREADY = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(axi_AWREADY), 0);
    chk("rst_arready", 32'(axi_ARREADY), 0);
    chk("rst_wready", 32'(axi_WREADY), 0);
    chk("rst_bvalid", 32'(axi_BVALID), 0);
    chk("rst_rvalid", 32'(axi_RVALID), 0);
    chk("rst_rlast", 32'(axi_RLAST), 0);
    chk("rst_bresp", 32'(axi_BRESP), 0);
    chk("rst_rresp", 32'(axi_RRESP), 0);
    chk("rst_rdata", axi_R, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("awready_after_rst", 32'(axi_AWREADY), 1);
    chk("arready_after_rst", 32'(axi_ARREADY), 1);

    // single write / read
    wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    axi_write(32'h100, 4'd0, 2'b01, 0, resp, bk);
    chk("single_bresp", 32'(resp), 0);
    chk("single_b_latency", bk, 1);
    axi_read(32'h100, 4'd0, 2'b01, 1'b0);
    chk("single_rcnt", rcnt, 1);
    chk("single_rdata", rdata[0], 32'hDEADBEEF);
    chk("single_rlast", 32'(rlast_q[0]), 1);
    chk("single_r_latency", first_k, 2);
    chk("single_rresp", 32'(axi_RRESP), 0);

    // INCR 16 beats: zero prefill, then odd beats strobed to the low half
    for (int i = 0; i < 16; i++) begin wdata[i] = '0; wstrb[i] = 4'hF; end
    axi_write(32'h000, 4'd15, 2'b01, 15, resp, bk);
    for (int i = 0; i < 16; i++) begin
      wdata[i] = 32'hA5A50000 | 32'(i);
      wstrb[i] = (i % 2 == 1) ? 4'h3 : 4'hF;
    end
    axi_write(32'h000, 4'd15, 2'b01, 15, resp, bk);
    chk("incr_bresp", 32'(resp), 0);
    axi_read(32'h000, 4'd15, 2'b01, 1'b0);
    chk("incr_rcnt", rcnt, 16);
    for (int i = 0; i < 16; i++) begin
      e = (i % 2 == 1) ? 32'(i) : (32'hA5A50000 | 32'(i));
      chk($sformatf("incr_data%0d", i), rdata[i], e);
      chk($sformatf("incr_last%0d", i), 32'(rlast_q[i]), 32'(i == 15));
      chk($sformatf("incr_time%0d", i), beat_k[i], 2 + i);
    end

    // WRAP read 0x018 LEN=3 -> words 6,7,4,5
    idx[0] = 6; idx[1] = 7; idx[2] = 4; idx[3] = 5;
    axi_read(32'h018, 4'd3, 2'b10, 1'b0);
    chk("wrap_rcnt", rcnt, 4);
    for (int i = 0; i < 4; i++) begin
      e = (idx[i] % 2 == 1) ? 32'(idx[i]) : (32'hA5A50000 | 32'(idx[i]));
      chk($sformatf("wrap_data%0d", i), rdata[i], e);
      chk($sformatf("wrap_last%0d", i), 32'(rlast_q[i]), 32'(i == 3));
    end

    // random RREADY backpressure, LEN=7
    axi_read(32'h000, 4'd7, 2'b01, 1'b1);
    chk("bp_rcnt", rcnt, 8);
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 1) ? 32'(i) : (32'hA5A50000 | 32'(i));
      chk($sformatf("bp_data%0d", i), rdata[i], e);
    end

    // FIXED write: both beats land on 0x300, last one wins
    wdata[0] = 32'h0BADF00D; wdata[1] = 32'hCAFEF00D; wstrb[0] = 4'hF; wstrb[1] = 4'hF;
    axi_write(32'h300, 4'd1, 2'b00, 1, resp, bk);
    axi_read(32'h300, 4'd0, 2'b01, 1'b0);
    chk("fixed_data", rdata[0], 32'hCAFEF00D);

    // WLAST on beat 1 of a 4-beat burst
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'h11110000 + 32'(i); wstrb[i] = 4'hF; end
    axi_write(32'h200, 4'd3, 2'b01, 1, resp, bk);
    chk("wlast_err_bresp", 32'(resp), 2);
    axi_read(32'h200, 4'd3, 2'b01, 1'b0);
    chk("wlast_err_rcnt", rcnt, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wlast_err_data%0d", i), rdata[i], 32'h11110000 + 32'(i));

    // same-cycle AR and AW to 0x100: old data first, new data after
    axi_AW = 32'h100; axi_AWLEN = 0; axi_AWBURST = 2'b01; axi_AWVALID = 1;
    axi_W = 32'h12345678; axi_WSTRB = 4'hF; axi_WLAST = 1; axi_WVALID = 1;
    axi_AR = 32'h100; axi_ARLEN = 0; axi_ARBURST = 2'b01; axi_ARVALID = 1;
    axi_RREADY = 1; axi_BREADY = 1;
    @(negedge clk);
    axi_AWVALID = 0; axi_ARVALID = 0;
    chk("conc_awready", 32'(axi_AWREADY), 0);
    chk("conc_arready", 32'(axi_ARREADY), 0);
    @(negedge clk);
    axi_WVALID = 0; axi_WLAST = 0;
    chk("conc_rvalid_early", 32'(axi_RVALID), 0);
    @(negedge clk);
    chk("conc_rvalid", 32'(axi_RVALID), 1);
    chk("conc_old_data", axi_R, 32'hDEADBEEF);
    chk("conc_rlast", 32'(axi_RLAST), 1);
    chk("conc_bvalid", 32'(axi_BVALID), 1);
    @(negedge clk);
    axi_RREADY = 0; axi_BREADY = 0;
    chk("conc_arready_back", 32'(axi_ARREADY), 1);
    chk("conc_awready_back", 32'(axi_AWREADY), 1);
    axi_read(32'h100, 4'd0, 2'b01, 1'b0);
    chk("conc_new_data", rdata[0], 32'h12345678);

    // reset in the middle of a stalled read
    axi_AR = 32'h000; axi_ARLEN = 4'd7; axi_ARBURST = 2'b01; axi_ARVALID = 1; axi_RREADY = 0;
    @(negedge clk);
    axi_ARVALID = 0;
    repeat (3) @(negedge clk);
    chk("midrst_rvalid_before", 32'(axi_RVALID), 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(axi_RVALID), 0);
    chk("midrst_rlast", 32'(axi_RLAST), 0);
    chk("midrst_arready", 32'(axi_ARREADY), 0);
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_arready_release", 32'(axi_ARREADY), 0);
    @(negedge clk);
    chk("midrst_arready_edge", 32'(axi_ARREADY), 1);
    axi_read(32'h100, 4'd0, 2'b01, 1'b0);
    chk("midrst_mem_kept", rdata[0], 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
